// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed seven-segment scanner:
// segment codes (g..a, active-high), the blank pattern and the dp bit position.
package seven_seg_pkg;

  localparam int DP_BIT = 7;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [6:0] SEG_OFF   = SEG_BLANK[6:0];

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

endpackage

// File: rtl/seg_decoder.sv
// Combinational nibble-to-segment decoder; letters A-F only when hex_en is set.
module seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_en,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: seg gets a default before the case so no path can leave it unassigned (no latch).
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: if (hex_en) seg = SEG_A;
      4'hB: if (hex_en) seg = SEG_B;
      4'hC: if (hex_en) seg = SEG_C;
      4'hD: if (hex_en) seg = SEG_D;
      4'hE: if (hex_en) seg = SEG_E;
      4'hF: if (hex_en) seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scanner with staged/shadowed display data so a
// frame never mixes old and new digits, plus optional leading-zero blanking.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 5,
  parameter int SCAN_DIV   = 50000,
  parameter int HEX_EN     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    upd,
  input  logic                    en,
  input  logic                    lz_blank,
  output logic [NUM_DIGITS-1:0]   SEG_SEL,
  output logic [7:0]              SEG_DATA,
  output logic                    frame_done
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic             HEX_ON   = (HEX_EN != 0);

  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] stage_dig_q, stage_dig_d;
  logic [NUM_DIGITS-1:0]   stage_dp_q, stage_dp_d;
  logic [4*NUM_DIGITS-1:0] shadow_dig_q, shadow_dig_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic                    pending_q, pending_d;
  logic [NUM_DIGITS-1:0]   seg_sel_q, seg_sel_d;
  logic [7:0]              seg_data_q, seg_data_d;
  logic                    frame_done_q, frame_done_d;

  logic       tick, wrap;
  logic [3:0] cur_nib;
  logic       cur_dp;
  logic       cur_lz;
  logic [6:0] dec_seg;

  // Timing and double-buffered display data.
  always_comb begin
    tick = (presc_q == PRE_LAST);
    wrap = tick && (idx_q == IDX_LAST);

    presc_d = tick ? '0 : presc_q + PRE_W'(1);
    idx_d   = idx_q;
    if (tick) idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    frame_done_d = wrap;

    stage_dig_d  = stage_dig_q;
    stage_dp_d   = stage_dp_q;
    shadow_dig_d = shadow_dig_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;

    if (wrap && pending_q) begin
      shadow_dig_d = stage_dig_q;
      shadow_dp_d  = stage_dp_q;
      pending_d    = 1'b0;
    end
    // A new capture always wins, so an update landing on a wrap waits for the next one.
    if (upd) begin
      stage_dig_d = digits;
      stage_dp_d  = dp;
      pending_d   = 1'b1;
    end
  end

  // Select the active digit and whether it is a leading zero.
  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib = shadow_dig_q[4*k +: 4];
        cur_dp  = shadow_dp_q[k];
        cur_lz  = (k != 0);
        for (int j = k; j < NUM_DIGITS; j++) begin
          if (shadow_dig_q[4*j +: 4] != 4'h0) cur_lz = 1'b0;
        end
      end
    end
  end

  seg_decoder u_dec (
    .nibble (cur_nib),
    .hex_en (HEX_ON),
    .seg    (dec_seg)
  );

  always_comb begin
    seg_sel_d  = '0;
    seg_data_d = SEG_BLANK;
    if (en) begin
      seg_sel_d              = NUM_DIGITS'(1) << idx_q;
      seg_data_d[DP_BIT]     = cur_dp;
      seg_data_d[DP_BIT-1:0] = (lz_blank && cur_lz) ? SEG_OFF : dec_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      stage_dig_q  <= '0;
      stage_dp_q   <= '0;
      shadow_dig_q <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      seg_sel_q    <= '0;
      seg_data_q   <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      stage_dig_q  <= stage_dig_d;
      stage_dp_q   <= stage_dp_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      seg_sel_q    <= seg_sel_d;
      seg_data_q   <= seg_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign SEG_SEL    = seg_sel_q;
  assign SEG_DATA   = seg_data_q;
  assign frame_done = frame_done_q;

endmodule
